// File: rtl/pipe_elastic_reg.sv
// Elastic pipeline register: DEPTH-entry circular buffer with valid/ready on both sides,
// synchronous flush, output-side stall and a registered output that reads zero when empty.
module pipe_elastic_reg #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             stall_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [CW-1:0]    count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Ready is a pure function of registered occupancy, so a pop never frees space same-cycle.
  assign in_ready_o  = (count_q != CW'(DEPTH));
  assign out_valid_o = (count_q != '0) & ~stall_i;
  assign push        = in_valid_i & in_ready_o & ~flush_i;
  assign pop         = out_valid_o & out_ready_i & ~flush_i;
  assign count_o     = count_q;
  // Popped and flushed slots are cleared, so the head slot already reads zero when empty.
  assign out_data_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= in_data_i;
      if (pop)  mem_q[rd_ptr_q] <= '0;
    end
  end

  a_count_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_q <= CW'(DEPTH));
  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (count_q == CW'(DEPTH)) |-> !push);
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (count_q == '0) |-> !pop);

endmodule

// File: tb/tb_pipe_elastic_reg.sv
// Bench for pipe_elastic_reg: DEPTH=2 and DEPTH=3 instances share stimulus; an array-based
// FIFO model predicts flags and a per-instance expected-data queue is checked on every pop.
module tb_pipe_elastic_reg;

  localparam int W = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          flush = 1'b0, stall = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0]  in_data = '0;

  logic          in_ready  [2];
  logic          out_valid [2];
  logic [W-1:0]  out_data  [2];
  logic [1:0]    count     [2];

  int            n_tests = 0;
  int            n_fail  = 0;

  logic [W-1:0]  mdat [2][16];
  int            mcnt [2];

  always #5 clk = ~clk;

  pipe_elastic_reg #(.WIDTH(W), .DEPTH(2)) u_d2 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .stall_i(stall),
    .in_valid_i(in_valid), .in_ready_o(in_ready[0]), .in_data_i(in_data),
    .out_valid_o(out_valid[0]), .out_ready_i(out_ready), .out_data_o(out_data[0]),
    .count_o(count[0]));

  pipe_elastic_reg #(.WIDTH(W), .DEPTH(3)) u_d3 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .stall_i(stall),
    .in_valid_i(in_valid), .in_ready_o(in_ready[1]), .in_data_i(in_data),
    .out_valid_o(out_valid[1]), .out_ready_i(out_ready), .out_data_o(out_data[1]),
    .count_o(count[1]));

  task automatic cmp(input string nm, input int depth, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s D=%0d t=%0t got %h expected %h", nm, depth, $time, act, exp);
    end
  endtask

  // Compare DUT against the model's pre-edge state, then advance the model across the edge.
  task automatic step(input int k, input int depth);
    bit m_ir, m_ov, do_push, do_pop;
    if (!rst_n) mcnt[k] = 0;
    m_ir = (mcnt[k] != depth);
    m_ov = (mcnt[k] != 0) && !stall;
    cmp("in_ready",  depth, W'(in_ready[k]),  W'(m_ir));
    cmp("out_valid", depth, W'(out_valid[k]), W'(m_ov));
    cmp("count",     depth, W'(count[k]),     W'(mcnt[k]));
    if (mcnt[k] == 0) cmp("out_data_empty", depth, out_data[k], '0);
    else if (!m_ov || !out_ready) cmp("out_data_head", depth, out_data[k], mdat[k][0]);
    if (!rst_n) return;
    if (flush) begin
      mcnt[k] = 0;
      return;
    end
    do_pop  = m_ov && out_ready;
    do_push = in_valid && m_ir;
    if (do_pop) begin
      cmp("pop_data", depth, out_data[k], mdat[k][0]);
      for (int i = 0; i < 15; i++) mdat[k][i] = mdat[k][i+1];
      mcnt[k]--;
    end
    if (do_push) begin
      mdat[k][mcnt[k]] = in_data;
      mcnt[k]++;
    end
  endtask

  always @(negedge clk) begin
    step(0, 2);
    step(1, 3);
  end

  task automatic cyc(input bit v, input logic [W-1:0] d, input bit ordy, input bit stl,
                     input bit fl);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    stall     = stl;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    mcnt[0] = 0;
    mcnt[1] = 0;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 64'hDEAD;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(0, '0, 1, 0, 0);

    cyc(1, 64'h11, 1, 0, 0);
    cyc(1, 64'h22, 1, 0, 0);
    cyc(1, 64'h33, 1, 0, 0);
    cyc(0, '0, 1, 0, 0);
    cyc(0, '0, 1, 0, 0);

    cyc(1, 64'hA, 0, 0, 0);
    cyc(1, 64'hB, 0, 0, 0);
    cyc(1, 64'hC, 0, 0, 0);
    cyc(0, '0, 0, 0, 0);
    repeat (5) cyc(0, '0, 1, 0, 0);

    cyc(1, 64'h5, 0, 0, 0);
    cyc(1, 64'h6, 0, 1, 0);
    cyc(0, '0, 1, 1, 0);
    repeat (4) cyc(0, '0, 1, 0, 0);

    cyc(1, 64'h7, 0, 0, 0);
    cyc(1, 64'h8, 0, 0, 0);
    cyc(1, 64'h9, 0, 1, 1);
    repeat (3) cyc(0, '0, 1, 0, 0);

    for (int n = 0; n < 300; n++) begin
      cyc($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom_range(0, 1) == 1,
          $urandom_range(0, 7) == 0, $urandom_range(0, 40) == 0);
      if (n == 150) begin
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
    end

    repeat (6) cyc(0, '0, 1, 0, 0);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
